icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 115 +++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one word per line.
// Lookups are combinational; a miss issues a single refill request and waits for mem_ready.
module icache #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        hit,
    output logic [31:0] hit_inst,
    input  logic        rob_clear,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    state_e                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [TAG_W-1:0]        tag_d  [LINES];
    logic [31:0]             data_q [LINES];
    logic [31:0]             data_d [LINES];
    logic [31:0]             last_inst_q, last_inst_d;
    logic                    mem_req_valid_q, mem_req_valid_d;
    logic [31:0]             mem_req_addr_q, mem_req_addr_d;

    logic [INDEX_BITS-1:0]   fetch_idx;
    logic [TAG_W-1:0]        fetch_tag;
    logic [INDEX_BITS-1:0]   miss_idx;
    logic [TAG_W-1:0]        miss_tag;
    logic                    unused_pc_lsbs;

    assign fetch_idx      = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag      = fetch_pc[31:INDEX_BITS+2];
    assign miss_idx       = mem_req_addr_q[INDEX_BITS+1:2];
    assign miss_tag       = mem_req_addr_q[31:INDEX_BITS+2];
    assign unused_pc_lsbs = ^fetch_pc[1:0];

    // Lookup reads the registered arrays, so a fill is only visible after its edge.
    assign hit      = fetch_valid & valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag);
    assign hit_inst = hit ? data_q[fetch_idx] : last_inst_q;

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        tag_d           = tag_q;
        data_d          = data_q;
        last_inst_d     = last_inst_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;

        if (rdy_in) begin
            if (hit) begin
                last_inst_d = data_q[fetch_idx];
            end
            case (state_q)
                IDLE: begin
                    if (fetch_valid && !hit && !rob_clear) begin
                        state_d         = MISS;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {fetch_pc[31:2], 2'b00};
                    end
                end
                MISS: begin
                    // A flush does not cancel the refill; the fetched word is still correct.
                    if (mem_ready) begin
                        state_d           = IDLE;
                        mem_req_valid_d   = 1'b0;
                        valid_d[miss_idx] = 1'b1;
                        tag_d[miss_idx]   = miss_tag;
                        data_d[miss_idx]  = mem_data;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            last_inst_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            last_inst_q     <= last_inst_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    // Tag and data need no reset: the valid bits gate every lookup.
    always_ff @(posedge clk_in) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule
